// File: rtl/pmem_responder.sv
// pmem_responder: single-outstanding AXI-lite-style memory responder with programmable
// read/write latency; the only caller of the n_pmem_read / n_pmem_write memory hooks.

package pmem_dpi_pkg;
   // Behavioural physical memory standing in for the host-side DPI layer.
   logic [31:0] mem [logic [31:0]];
   int unsigned rd_calls = 0;
   int unsigned wr_calls = 0;

   function automatic void pmem_preload(input logic [31:0] addr, input logic [31:0] data);
      mem[addr] = data;
   endfunction

   function automatic logic [31:0] n_pmem_read(input logic [31:0] addr);
      rd_calls++;
      if (mem.exists(addr)) return mem[addr];
      return 32'h0;
   endfunction

   function automatic void n_pmem_write(input logic [31:0] addr, input logic [31:0] data,
                                        input logic [7:0] mask);
      logic [31:0] word;
      word = mem.exists(addr) ? mem[addr] : 32'h0;
      // Mask bits above the 4 byte lanes of a 32-bit word have no effect.
      for (int i = 0; i < 8; i++)
         if (mask[i] && i < 4) word[8*(i%4) +: 8] = data[8*(i%4) +: 8];
      mem[addr] = word;
      wr_calls++;
   endfunction
endpackage

module pmem_responder
   import pmem_dpi_pkg::*;
#(
   parameter int unsigned RD_LAT = 1,
   parameter int unsigned WR_LAT = 1,
   parameter logic [31:0] BASE   = 32'h8000_0000,
   parameter logic [31:0] SIZE   = 32'h0800_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] araddr,
   input  logic        arvalid,
   output logic        arready,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rvalid,
   input  logic        rready,
   input  logic [31:0] awaddr,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wvalid,
   output logic        wready,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready
);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP} state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;
   logic [31:0] word_addr;
   logic        in_window;

   assign word_addr = {addr_q[31:2], 2'b00};
   // 33-bit compare so a window ending exactly at 2^32 still decodes correctly.
   assign in_window = (addr_q >= BASE) &&
                      ({1'b0, addr_q} < ({1'b0, BASE} + {1'b0, SIZE}));

   // NOTE: readies are plain continuous assigns of state and inputs, so no
   // incompletely-assigned combinational block can infer a latch; gating with
   // rst forces them low for the whole reset window.
   assign arready = rst && (state == IDLE);
   assign awready = arready && awvalid && wvalid && !arvalid;
   assign wready  = awready;

   // NOTE: all state is updated with non-blocking assignments so every register
   // samples pre-edge values; the latched request registers are reset as well so
   // the response outputs are never X after reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         wstrb_q <= 4'h0;
         rdata   <= 32'h0;
         rresp   <= RESP_OKAY;
         bresp   <= RESP_OKAY;
         rvalid  <= 1'b0;
         bvalid  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (arvalid) begin
                  addr_q <= araddr;
                  cnt    <= 4'(RD_LAT - 1);
                  state  <= RD_WAIT;
               end else if (awvalid && wvalid) begin
                  addr_q  <= awaddr;
                  wdata_q <= wdata;
                  wstrb_q <= wstrb;
                  cnt     <= 4'(WR_LAT - 1);
                  state   <= WR_WAIT;
               end
            end
            RD_WAIT: begin
               if (cnt == 4'd0) begin
                  if (in_window) begin
                     rdata <= n_pmem_read(word_addr);
                     rresp <= RESP_OKAY;
                  end else begin
                     rdata <= 32'h0;
                     rresp <= RESP_DECERR;
                  end
                  rvalid <= 1'b1;
                  state  <= RD_RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RD_RESP: begin
               if (rready) begin
                  rvalid <= 1'b0;
                  state  <= IDLE;
               end
            end
            WR_WAIT: begin
               if (cnt == 4'd0) begin
                  if (in_window) begin
                     n_pmem_write(word_addr, wdata_q, {4'b0, wstrb_q});
                     bresp <= RESP_OKAY;
                  end else begin
                     bresp <= RESP_DECERR;
                  end
                  bvalid <= 1'b1;
                  state  <= WR_RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            WR_RESP: begin
               if (bready) begin
                  bvalid <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/pmem_responder.md
# pmem_responder

Memory-side responder that serves the fetch and load/store requests issued by the core's ifu and lsu. It provides a valid/ready read channel and a valid/ready write channel with AXI-lite-style semantics and a programmable response latency. It is the single owner of the `n_pmem_read`/`n_pmem_write` DPI calls, which replace direct DPI calls inside the core units. It handles one transaction at a time.

## Interface
Parameters:
- `RD_LAT`, 1: cycles from read-address acceptance to `rvalid`; legal range 1..15.
- `WR_LAT`, 1: cycles from write acceptance to `bvalid`; legal range 1..15.
- `BASE`, 32'h80000000: first valid physical address.
- `SIZE`, 32'h08000000: valid window size in bytes.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk` input 1: the single clock.
  - `rst` input 1: asynchronous reset, asserted low.
- Read address channel:
  - `araddr` input 32: read address.
  - `arvalid` input 1: read request valid.
  - `arready` output 1: read request accepted.
- Read data channel:
  - `rdata` output 32: read data word.
  - `rresp` output 2: read status; 00 OKAY, 11 DECERR.
  - `rvalid` output 1: read data valid.
  - `rready` input 1: initiator accepts read data.
- Write address channel:
  - `awaddr` input 32: write address.
  - `awvalid` input 1: write address valid.
  - `awready` output 1: write address accepted.
- Write data channel:
  - `wdata` input 32: write data.
  - `wstrb` input 4: byte enables.
  - `wvalid` input 1: write data valid.
  - `wready` output 1: write data accepted.
- Write response channel:
  - `bresp` output 2: write status; 00 OKAY, 11 DECERR.
  - `bvalid` output 1: write response valid.
  - `bready` input 1: initiator accepts write response.

## Operation
- FSM states: IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP.
- Request acceptance:
  - IDLE: `arready` = 1.
  - IDLE: `awready` = `wready` = (`awvalid` & `wvalid` & ~`arvalid`).
  - All ready outputs are 0 in every other state.
  - A write is accepted only when address and data are both valid in the same cycle. A lone `awvalid` or lone `wvalid` is not accepted.
- Arbitration: `arvalid` and a complete write present in the same IDLE cycle → the read wins. The write waits; its inputs must stay stable.
- On acceptance:
  - Latch the address; for writes, also latch the data and strobe.
  - Load the 4-bit latency counter with LAT-1.
  - Enter RD_WAIT or WR_WAIT.
- WAIT states: the counter decrements each cycle. When the counter is 0, the next edge does the following:
  - Read, address in window (`BASE` ≤ addr < `BASE+SIZE`, unsigned 32-bit compare):
    - Call `n_pmem_read(addr & ~3)`.
    - Register the result into `rdata`; `rresp` = 00.
    - Enter RD_RESP.
  - Read, address out of window:
    - No DPI call.
    - `rdata` = 0, `rresp` = 11.
    - Enter RD_RESP.
  - Write, address in window:
    - Call `n_pmem_write(addr & ~3, wdata, {4'b0, wstrb})`.
    - `bresp` = 00.
    - Enter WR_RESP.
  - Write, address out of window:
    - No DPI call.
    - `bresp` = 11.
    - Enter WR_RESP.
  - `wstrb` = 0 in window → the DPI call is made with mask 0 and `bresp` = 00.
- Response states:
  - RD_RESP: `rvalid` = 1. `rdata`/`rresp` are held stable until `rvalid & rready`; on that edge, return to IDLE.
  - WR_RESP: `bvalid` = 1. `bresp` is held stable until `bvalid & bready`; on that edge, return to IDLE.
- Exactly one DPI call per accepted in-window transaction. No DPI call is made in any other cycle.
- Sub-word alignment and sign extension are done by the lsu. The responder always returns the full aligned word.

## Timing
- Reset (`rst` low, takes effect immediately without a clock edge):
  - State → IDLE; counter → 0.
  - `rdata` = 0, `rresp` = 00, `bresp` = 00.
  - `rvalid` = `bvalid` = 0.
  - `arready` = `awready` = `wready` = 0 while `rst` is low.
  - `arready` = 1 in the first cycle after release.
- Reset mid-transaction:
  - The pending transaction is dropped with no DPI call.
  - A response already presented is withdrawn.
- Read latency: accept at edge T → `rvalid` high from edge T+`RD_LAT`. Minimum occupancy is `RD_LAT`+1 cycles per read with `rready` held high.
- Write latency: accept at edge T → `bvalid` high from edge T+`WR_LAT`.
- Back-to-back:
  - After the response handshake edge, IDLE readies are high in the next cycle.
  - No request is accepted in the same cycle as a response handshake.
- `rready`/`bready` may be high before valid. The handshake completes in the first cycle that valid is high.
- Counter width: 4 bits. LAT=1 loads 0, so the response rises one edge after acceptance.

## Test plan
- Reset then read: `rst` low for 3 cycles then high; memory word at 0x80000000 = 0x00100093; `araddr`=0x80000000, `arvalid`=1, `rready`=1, `RD_LAT`=1 → accept at edge 1, `rvalid`=1 with `rdata`=0x00100093 and `rresp`=00 after edge 2, `arready`=1 again after edge 3.
- Write then read back: `awaddr`=0x80000104, `wdata`=0xAABBCCDD, `wstrb`=0011 → after the `bvalid` handshake, a read of 0x80000104 returns 0xXXXXCCDD, where the upper bytes are unchanged from before the write; `bresp`=00.
- Backpressure: `RD_LAT`=3, `rready`=0 for 5 cycles after `rvalid` → `rvalid` and `rdata` stay stable and `arready`=0 throughout; one DPI read only.
- Out-of-window: reads of 0x00000000 and 0x88000000, and a write to 0x7FFFFFFC → `rresp`=11 with `rdata`=0, `bresp`=11; zero DPI calls logged.
- Contention: `arvalid`, `awvalid` and `wvalid` all asserted in the same IDLE cycle → the read is served first; the write is accepted in the first IDLE cycle after the read handshake.
- Mid-op reset: `rst` pulled low while in RD_WAIT with `RD_LAT`=4 → `rvalid` never rises, no DPI call; after release, a new read completes normally.
